// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU sequencer: element widths, chunk
// geometry, sequencer states and the vec_alu opcode constants.
package vec_pkg;

    localparam int CHUNK_W     = 128;
    localparam int CHUNK_BYTES = 16;

    typedef enum logic [2:0] {
        E8  = 3'd0,
        E16 = 3'd1,
        E32 = 3'd2,
        E64 = 3'd3
    } vsew_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EXEC,
        WB,
        FIN
    } seq_state_e;

    localparam logic [5:0] OP_VADD = 6'b000000;
    localparam logic [5:0] OP_VAND = 6'b001001;
    localparam logic [5:0] OP_VOR  = 6'b001010;
    localparam logic [5:0] OP_VXOR = 6'b001011;

    // Maximum element count of one register group for a legal element width.
    function automatic int unsigned vlmax_elems(input int unsigned vlen, input logic [1:0] vsew);
        return (vlen / 8) >> vsew;
    endfunction

endpackage

// File: rtl/vec_tail_mask.sv
// Converts the number of bytes still to be written in the current chunk into
// a byte-enable mask; full chunks get every byte, the tail chunk only its
// leading bytes so that bytes past vl are left undisturbed.
module vec_tail_mask
    import vec_pkg::*;
#(
    parameter int REM_W = 7
) (
    input  logic [REM_W-1:0]       rem,
    output logic [CHUNK_BYTES-1:0] mask
);

    // Saturate to a full mask once at least one whole chunk remains.
    always_comb begin
        if (rem >= REM_W'(CHUNK_BYTES)) begin
            mask = '1;
        end else begin
            mask = (CHUNK_BYTES'(1) << rem[3:0]) - CHUNK_BYTES'(1);
        end
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Streams one vector instruction over a full register group, one 128-bit
// chunk at a time: read vs1/vs2 chunk, run the shared vec_alu, write the
// result chunk back with a tail byte mask, then report completion.
module vec_alu_seq
    import vec_pkg::*;
#(
    parameter int VLEN = 512
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [5:0]                           in_opcode,
    input  logic [4:0]                           in_vs1,
    input  logic [4:0]                           in_vs2,
    input  logic [4:0]                           in_vd,
    input  logic [2:0]                           in_vsew,
    input  logic [$clog2(VLEN/8):0]              in_vl,
    output logic [4+$clog2(VLEN/CHUNK_W):0]      rf_raddr1,
    output logic [4+$clog2(VLEN/CHUNK_W):0]      rf_raddr2,
    input  logic [CHUNK_W-1:0]                   rf_rdata1,
    input  logic [CHUNK_W-1:0]                   rf_rdata2,
    output logic                                 rf_we,
    output logic [4+$clog2(VLEN/CHUNK_W):0]      rf_waddr,
    output logic [CHUNK_W-1:0]                   rf_wdata,
    output logic [CHUNK_BYTES-1:0]               rf_wmask,
    output logic [5:0]                           alu_opcode,
    output logic [2:0]                           alu_vsew,
    output logic                                 alu_run,
    output logic [CHUNK_W-1:0]                   alu_vs1,
    output logic [CHUNK_W-1:0]                   alu_vs2,
    input  logic [CHUNK_W-1:0]                   alu_vd,
    input  logic                                 alu_done,
    output logic                                 busy,
    output logic                                 out_done,
    output logic                                 out_err
);

    localparam int NCHUNK = VLEN / CHUNK_W;
    localparam int CIDX_W = $clog2(NCHUNK);
    localparam int VLW    = $clog2(VLEN/8) + 1;
    localparam int NCH_W  = CIDX_W + 1;

    seq_state_e        state;
    logic [4:0]        vs1_q;
    logic [4:0]        vs2_q;
    logic [4:0]        vd_q;
    logic [VLW-1:0]    total_q;
    logic [NCH_W-1:0]  nchunks_q;
    logic [CIDX_W-1:0] k;
    logic              exec_first;

    logic [VLW-1:0]    vlmax;
    logic [VLW-1:0]    vl_eff;
    logic [VLW-1:0]    total_bytes;
    logic [VLW:0]      total_round;
    logic [NCH_W-1:0]  nchunks;
    logic [VLW-1:0]    rem_bytes;
    logic [CHUNK_BYTES-1:0] tail_mask;
    logic [NCH_W-1:0]  k_next;

    // Clamp the offered vl to VLMAX and size the instruction in bytes and chunks.
    always_comb begin
        vlmax       = VLW'(vlmax_elems(VLEN, in_vsew[1:0]));
        vl_eff      = (in_vl > vlmax) ? vlmax : in_vl;
        total_bytes = vl_eff << in_vsew[1:0];
        total_round = {1'b0, total_bytes} + (VLW+1)'(CHUNK_BYTES - 1);
        nchunks     = NCH_W'(total_round >> 4);
    end

    assign rem_bytes = total_q - VLW'({k, 4'b0000});
    assign k_next    = NCH_W'(k) + NCH_W'(1);

    vec_tail_mask #(
        .REM_W (VLW)
    ) u_tail_mask (
        .rem  (rem_bytes),
        .mask (tail_mask)
    );

    // Sequencer FSM: all handshake, VRF and ALU-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            rf_we      <= 1'b0;
            alu_run    <= 1'b0;
            out_done   <= 1'b0;
            out_err    <= 1'b0;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_wmask   <= '0;
            alu_opcode <= '0;
            alu_vsew   <= '0;
            alu_vs1    <= '0;
            alu_vs2    <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            vd_q       <= '0;
            total_q    <= '0;
            nchunks_q  <= '0;
            k          <= '0;
            exec_first <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            out_done <= 1'b0;
            out_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        alu_opcode <= in_opcode;
                        alu_vsew   <= in_vsew;
                        vs1_q      <= in_vs1;
                        vs2_q      <= in_vs2;
                        vd_q       <= in_vd;
                        total_q    <= total_bytes;
                        nchunks_q  <= nchunks;
                        k          <= '0;
                        if (in_vsew > E64) begin
                            state    <= FIN;
                            out_done <= 1'b1;
                            out_err  <= 1'b1;
                        end else if (in_vl == '0) begin
                            state    <= FIN;
                            out_done <= 1'b1;
                        end else begin
                            state     <= RD;
                            rf_raddr1 <= {in_vs1, CIDX_W'(0)};
                            rf_raddr2 <= {in_vs2, CIDX_W'(0)};
                        end
                    end
                end
                RD: begin
                    state      <= EXEC;
                    alu_run    <= 1'b1;
                    exec_first <= 1'b1;
                end
                EXEC: begin
                    if (exec_first) begin
                        alu_vs1    <= rf_rdata1;
                        alu_vs2    <= rf_rdata2;
                        exec_first <= 1'b0;
                    end else if (alu_done) begin
                        alu_run  <= 1'b0;
                        rf_we    <= 1'b1;
                        rf_waddr <= {vd_q, k};
                        rf_wdata <= alu_vd;
                        rf_wmask <= tail_mask;
                        state    <= WB;
                    end
                end
                WB: begin
                    if (k_next < nchunks_q) begin
                        k         <= k_next[CIDX_W-1:0];
                        rf_raddr1 <= {vs1_q, k_next[CIDX_W-1:0]};
                        rf_raddr2 <= {vs2_q, k_next[CIDX_W-1:0]};
                        state     <= RD;
                    end else begin
                        state    <= FIN;
                        out_done <= 1'b1;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    alu_run  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: models the VRF and the vec_alu,
// predicts every write-back from element counts and byte positions, and
// checks handshake, latency, stalls and reset behaviour.
module tb_vec_alu_seq;
    import vec_pkg::*;

    localparam int VLEN   = 512;
    localparam int NCHUNK = VLEN / CHUNK_W;
    localparam int CIDX_W = $clog2(NCHUNK);
    localparam int AW     = 5 + CIDX_W;
    localparam int VLW    = $clog2(VLEN/8) + 1;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    logic [5:0] in_opcode;
    logic [4:0] in_vs1, in_vs2, in_vd;
    logic [2:0] in_vsew;
    logic [VLW-1:0] in_vl;
    logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [127:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic rf_we;
    logic [15:0] rf_wmask;
    logic [5:0] alu_opcode;
    logic [2:0] alu_vsew;
    logic alu_run;
    logic [127:0] alu_vs1, alu_vs2, alu_vd;
    logic alu_done;
    logic busy, out_done, out_err;

    int checks = 0;
    int failures = 0;
    int alu_lat = 3;
    bit spurious = 1'b0;
    int run_cnt = 0;
    int unstable = 0;
    logic [127:0] held_vs1, held_vs2;
    logic [127:0] vrf [0:32*NCHUNK-1];
    logic [127:0] last_data;
    logic [15:0] last_mask;

    vec_alu_seq #(.VLEN(VLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd), .in_vsew(in_vsew), .in_vl(in_vl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wmask(rf_wmask),
        .alu_opcode(alu_opcode), .alu_vsew(alu_vsew), .alu_run(alu_run),
        .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_vd(alu_vd), .alu_done(alu_done),
        .busy(busy), .out_done(out_done), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Element-wise reference for the vec_alu operations used here.
    function automatic logic [127:0] alu_ref(input logic [5:0] op, input logic [2:0] vsew,
                                             input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        logic [63:0] m, ea, eb;
        int w;
        r = '0;
        w = 8 << vsew[1:0];
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (op)
            OP_VAND: r = a & b;
            OP_VOR:  r = a | b;
            OP_VXOR: r = a ^ b;
            default: begin
                for (int e = 0; e < 128 / w; e++) begin
                    ea = 64'(a >> (e * w)) & m;
                    eb = 64'(b >> (e * w)) & m;
                    r = r | (128'((ea + eb) & m) << (e * w));
                end
            end
        endcase
        return r;
    endfunction

    // Register file read port with one cycle of latency.
    always @(posedge clk) begin
        rf_rdata1 <= vrf[rf_raddr1];
        rf_rdata2 <= vrf[rf_raddr2];
    end

    // Register file byte-masked write port.
    always @(negedge clk) begin
        if (rf_we) begin
            for (int b = 0; b < 16; b++) begin
                if (rf_wmask[b]) vrf[rf_waddr][b*8 +: 8] = rf_wdata[b*8 +: 8];
            end
        end
    end

    // vec_alu model: raises alu_done in the alu_lat-th cycle of alu_run.
    always @(negedge clk) begin
        if (alu_run) begin
            run_cnt++;
            if (run_cnt == 2) begin
                held_vs1 = alu_vs1;
                held_vs2 = alu_vs2;
            end else if (run_cnt > 2 && (alu_vs1 !== held_vs1 || alu_vs2 !== held_vs2)) begin
                unstable++;
            end
            alu_done = (run_cnt == alu_lat);
            alu_vd = alu_ref(alu_opcode, alu_vsew, alu_vs1, alu_vs2);
        end else begin
            run_cnt = 0;
            alu_done = spurious;
            alu_vd = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input int vs1, input int vs2, input int vd,
                                 input int vsew, input int vl, input int lat, input bit hold);
        logic [127:0] exp_data [NCHUNK];
        logic [15:0] exp_mask [NCHUNK];
        int nch, tbytes, vle, vlmax, nw, runs, rdy_busy, cyc, done_cyc;
        bit err, done_seen;
        err = (vsew > 3);
        nch = 0;
        tbytes = 0;
        if (!err) begin
            vlmax = VLEN / (8 << vsew);
            vle = (vl < vlmax) ? vl : vlmax;
            tbytes = vle * (1 << vsew);
            nch = (tbytes + 15) / 16;
        end
        for (int c = 0; c < nch; c++) begin
            exp_data[c] = alu_ref(op, 3'(vsew), vrf[vs1*NCHUNK + c], vrf[vs2*NCHUNK + c]);
            for (int b = 0; b < 16; b++) exp_mask[c][b] = (16*c + b < tbytes);
        end
        alu_lat = lat;
        unstable = 0;
        in_opcode = op;
        in_vs1 = 5'(vs1);
        in_vs2 = 5'(vs2);
        in_vd = 5'(vd);
        in_vsew = 3'(vsew);
        in_vl = VLW'(vl);
        in_valid = 1'b1;
        for (cyc = 0; cyc < 50 && !in_ready; cyc++) @(negedge clk);
        checkOutput("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        nw = 0; runs = 0; rdy_busy = 0; done_seen = 0; done_cyc = 0;
        for (cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
            @(negedge clk);
            if (in_ready) rdy_busy++;
            if (alu_run) runs++;
            if (rf_we) begin
                if (nw < nch) begin
                    checkOutput("wb_addr", 128'(rf_waddr), 128'(vd*NCHUNK + nw));
                    checkOutput("wb_data", rf_wdata, exp_data[nw]);
                    checkOutput("wb_mask", 128'(rf_wmask), 128'(exp_mask[nw]));
                end else begin
                    checkOutput("extra_we", 128'(rf_we), 128'(0));
                end
                last_data = rf_wdata;
                last_mask = rf_wmask;
                nw++;
            end
            if (out_done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                checkOutput("out_err", 128'(out_err), 128'(err));
            end
        end
        checkOutput("done_seen", 128'(done_seen), 128'(1));
        checkOutput("done_cycle", 128'(done_cyc), 128'(nch*(lat+2) + 1));
        checkOutput("write_count", 128'(nw), 128'(nch));
        checkOutput("run_cycles", 128'(runs), 128'(nch*lat));
        checkOutput("ready_while_busy", 128'(rdy_busy), 128'(0));
        checkOutput("operands_stable", 128'(unstable), 128'(0));
        if (hold) begin
            @(negedge clk);
            checkOutput("ready_after_done", 128'(in_ready), 128'(1));
        end
    endtask

    task automatic resetMidInstruction();
        int nw, cyc;
        bit hit;
        alu_lat = 5;
        in_opcode = OP_VADD; in_vs1 = 5'd4; in_vs2 = 5'd5; in_vd = 5'd20;
        in_vsew = 3'd2; in_vl = VLW'(16); in_valid = 1'b1;
        for (cyc = 0; cyc < 50 && !in_ready; cyc++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        nw = 0; hit = 0;
        for (cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge clk);
            if (rf_we) nw++;
            if (nw == 2 && alu_run) hit = 1'b1;
        end
        checkOutput("reached_exec_chunk2", 128'(hit), 128'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("rst_rf_we", 128'(rf_we), 128'(0));
        checkOutput("rst_alu_run", 128'(alu_run), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt, vs, vl, op;
        logic [5:0] ops [4];
        ops[0] = OP_VADD; ops[1] = OP_VAND; ops[2] = OP_VOR; ops[3] = OP_VXOR;
        reset = 1'b1;
        in_valid = 1'b0;
        in_opcode = '0; in_vs1 = '0; in_vs2 = '0; in_vd = '0; in_vsew = '0; in_vl = '0;
        alu_done = 1'b0;
        alu_vd = '0;
        for (int i = 0; i < 32*NCHUNK; i++) vrf[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_rf_we", 128'(rf_we), 128'(0));
        checkOutput("reset_alu_run", 128'(alu_run), 128'(0));
        checkOutput("reset_out_done", 128'(out_done), 128'(0));
        checkOutput("reset_out_err", 128'(out_err), 128'(0));
        checkOutput("reset_waddr", 128'(rf_waddr), 128'(0));
        checkOutput("reset_wmask", 128'(rf_wmask), 128'(0));
        checkOutput("reset_raddr", 128'(rf_raddr1), 128'(0));
        reset = 1'b0;

        $display("[TB] single chunk AND");
        vrf[1*NCHUNK] = 128'habcdabcdbeefbeef1234567887654321;
        vrf[2*NCHUNK] = 128'h8765432112345678beefbeefabcdabcd;
        applyStimulus(OP_VAND, 1, 2, 3, 3, 2, 3, 1'b0);
        checkOutput("t1_data", last_data, 128'h83450301122416681224166883450301);
        checkOutput("t1_mask", 128'(last_mask), 128'(16'hFFFF));

        $display("[TB] full group and tails");
        applyStimulus(OP_VADD, 4, 5, 6, 2, 16, 3, 1'b0);
        applyStimulus(OP_VXOR, 7, 8, 9, 1, 5, 2, 1'b0);
        checkOutput("tail_mask_03ff", 128'(last_mask), 128'(16'h03FF));
        applyStimulus(OP_VOR, 10, 11, 12, 3, 9, 2, 1'b0);
        checkOutput("clamp_last_mask", 128'(last_mask), 128'(16'hFFFF));

        $display("[TB] vl zero and illegal vsew");
        applyStimulus(OP_VADD, 1, 2, 14, 2, 0, 3, 1'b0);
        applyStimulus(OP_VADD, 1, 2, 15, 5, 10, 3, 1'b0);

        $display("[TB] backpressure and ALU stall");
        applyStimulus(OP_VAND, 1, 2, 13, 0, 40, 2, 1'b1);
        applyStimulus(OP_VADD, 16, 17, 18, 0, 50, 8, 1'b0);

        $display("[TB] spurious alu_done");
        spurious = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rf_we || busy) cnt++;
        end
        checkOutput("idle_spurious", 128'(cnt), 128'(0));
        applyStimulus(OP_VXOR, 19, 21, 22, 2, 13, 3, 1'b0);
        spurious = 1'b0;

        $display("[TB] reset mid instruction");
        resetMidInstruction();
        applyStimulus(OP_VADD, 23, 24, 25, 1, 30, 4, 1'b0);

        $display("[TB] random instructions");
        for (int n = 0; n < 25; n++) begin
            vs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            vl = $urandom_range(0, 80);
            op = $urandom_range(0, 3);
            applyStimulus(ops[op], $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          vs, vl, $urandom_range(2, 6), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
